bus_slave_mem: RTL and testbench



---
 rtl/az_bus_pkg.sv | 14 +
 rtl/bus_slave_mem_if.sv | 23 ++
 rtl/mem_array.sv | 26 ++
 rtl/bus_slave_mem.sv | 108 ++++++++++
 tb/tb_bus_slave_mem.sv | 203 ++++++++++++++++++++
 5 files changed

// File: rtl/az_bus_pkg.sv
// Shared bus definitions: slave FSM encoding, read/write and strobe levels, counter width.
// Imported by every block that sits on the processor's shared bus.
package az_bus_pkg;

    typedef enum logic [1:0] {IDLE, WAIT, RESP} bus_slv_state_t;

    localparam logic BUS_READ      = 1'b1;
    localparam logic BUS_WRITE     = 1'b0;
    localparam logic BUS_ENABLE_N  = 1'b0;
    localparam logic BUS_DISABLE_N = 1'b1;

    localparam int WAIT_CNT_W = 4;

endpackage

// File: rtl/bus_slave_mem_if.sv
// Shared-bus slave port: active-low select/strobe request, data out with active-low ready.
// par_err exists only when BUS_SLAVE_MEM_PARITY_EN is defined.
interface bus_slave_mem_if #(
    parameter int ADDR_W = 12,
    parameter int DATA_W = 32
);
    logic              cs_n;
    logic              as_n;
    logic              rw;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] wr_data;
    logic [DATA_W-1:0] rd_data;
    logic              rdy_n;
`ifdef BUS_SLAVE_MEM_PARITY_EN
    logic              par_err;

    modport master (output cs_n, as_n, rw, addr, wr_data, input rd_data, rdy_n, par_err);
    modport slave  (input cs_n, as_n, rw, addr, wr_data, output rd_data, rdy_n, par_err);
`else
    modport master (output cs_n, as_n, rw, addr, wr_data, input rd_data, rdy_n);
    modport slave  (input cs_n, as_n, rw, addr, wr_data, output rd_data, rdy_n);
`endif
endinterface

// File: rtl/mem_array.sv
// Single-port RAM, synchronous write, registered read (data valid the cycle after re).
// No backpressure; contents are not reset.
module mem_array #(
    parameter int ADDR_W = 12,
    parameter int WIDTH  = 32
) (
    input  logic              clk,
    input  logic              we,
    input  logic              re,
    input  logic [ADDR_W-1:0] addr,
    input  logic [WIDTH-1:0]  wdata,
    output logic [WIDTH-1:0]  rdata
);

    logic [WIDTH-1:0] mem [2**ADDR_W];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[addr] <= wdata;
        end
        if (re) begin
            rdata <= mem[addr];
        end
    end

endmodule

// File: rtl/bus_slave_mem.sv
// Wait-stated RAM slave: capture edge to rdy_n low takes WAIT_CYC+1 cycles, rdy_n is a one-cycle pulse.
// Requests outside IDLE are ignored (no queueing); BUS_SLAVE_MEM_PARITY_EN adds per-word even parity and par_err.
module bus_slave_mem
    import az_bus_pkg::*;
#(
    parameter int ADDR_W   = 12,
    parameter int DATA_W   = 32,
    parameter int WAIT_CYC = 1
) (
    input  logic             clk,
    input  logic             resetn,
    bus_slave_mem_if.slave   bus
);

    localparam logic [1:0] ST_IDLE = IDLE;
    localparam logic [1:0] ST_WAIT = WAIT;
    localparam logic [1:0] ST_RESP = RESP;

    localparam logic [WAIT_CNT_W-1:0] WAIT_LOAD = WAIT_CNT_W'(WAIT_CYC);
    localparam logic [WAIT_CNT_W-1:0] CNT_ONE   = WAIT_CNT_W'(1);

`ifdef BUS_SLAVE_MEM_PARITY_EN
    localparam int MEM_W = DATA_W + 1;
`else
    localparam int MEM_W = DATA_W;
`endif

    logic [1:0]            state;
    logic [WAIT_CNT_W-1:0] cnt;
    logic [ADDR_W-1:0]     cap_addr;
    logic                  cap_rw;
    logic [DATA_W-1:0]     cap_data;
    logic                  rdy_n_q;
    logic                  resp_rd;
    logic                  access;
    logic                  mem_we;
    logic                  mem_re;
    logic [MEM_W-1:0]      mem_wdata;
    logic [MEM_W-1:0]      mem_q;

    assign access = (bus.cs_n == BUS_ENABLE_N) && (bus.as_n == BUS_ENABLE_N);

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state    <= ST_IDLE;
            cnt      <= '0;
            cap_addr <= '0;
            cap_rw   <= 1'b0;
            cap_data <= '0;
            rdy_n_q  <= BUS_DISABLE_N;
            resp_rd  <= 1'b0;
        end else begin
            rdy_n_q <= (state == ST_RESP) ? BUS_ENABLE_N : BUS_DISABLE_N;
            resp_rd <= (state == ST_RESP) && (cap_rw == BUS_READ);
            case (state)
                ST_IDLE: begin
                    if (access) begin
                        cap_addr <= bus.addr;
                        cap_rw   <= bus.rw;
                        cap_data <= bus.wr_data;
                        cnt      <= WAIT_LOAD;
                        state    <= (WAIT_CYC == 0) ? ST_RESP : ST_WAIT;
                    end
                end
                ST_WAIT: begin
                    if (cnt == CNT_ONE) begin
                        cnt   <= '0;
                        state <= ST_RESP;
                    end else begin
                        cnt <= cnt - CNT_ONE;
                    end
                end
                ST_RESP: state <= ST_IDLE;
                default: state <= ST_IDLE;
            endcase
        end
    end

    // RAM is touched only on the RESP edge, so an access aborted by reset never writes.
    assign mem_we = (state == ST_RESP) && (cap_rw == BUS_WRITE);
    assign mem_re = (state == ST_RESP) && (cap_rw == BUS_READ);

`ifdef BUS_SLAVE_MEM_PARITY_EN
    assign mem_wdata = {^cap_data, cap_data};
`else
    assign mem_wdata = cap_data;
`endif

    mem_array #(
        .ADDR_W (ADDR_W),
        .WIDTH  (MEM_W)
    ) u_mem (
        .clk   (clk),
        .we    (mem_we),
        .re    (mem_re),
        .addr  (cap_addr),
        .wdata (mem_wdata),
        .rdata (mem_q)
    );

    // Registered RAM output gated by a registered flag keeps rd_data zero outside the pulse.
    assign bus.rdy_n   = rdy_n_q;
    assign bus.rd_data = resp_rd ? mem_q[DATA_W-1:0] : '0;
`ifdef BUS_SLAVE_MEM_PARITY_EN
    assign bus.par_err = resp_rd & (^mem_q);
`endif

endmodule

// File: tb/tb_bus_slave_mem.sv
// Directed bench for bus_slave_mem with WAIT_CYC = 0, 1 and 3 instances sharing one reset.
// Parity steps are included when BUS_SLAVE_MEM_PARITY_EN is defined.
module tb_bus_slave_mem;

    logic        clk = 1'b0;
    logic        resetn;
    logic        cs0, cs1, cs3;
    logic        as_n;
    logic        rw;
    logic [11:0] addr;
    logic [31:0] wdat;
    int          checks = 0;
    int          errors = 0;

    always #5 clk = ~clk;

    bus_slave_mem_if #(.ADDR_W(12), .DATA_W(32)) i0 ();
    bus_slave_mem_if #(.ADDR_W(12), .DATA_W(32)) i1 ();
    bus_slave_mem_if #(.ADDR_W(12), .DATA_W(32)) i3 ();

    assign i0.cs_n = cs0;  assign i0.as_n = as_n;  assign i0.rw = rw;
    assign i0.addr = addr; assign i0.wr_data = wdat;
    assign i1.cs_n = cs1;  assign i1.as_n = as_n;  assign i1.rw = rw;
    assign i1.addr = addr; assign i1.wr_data = wdat;
    assign i3.cs_n = cs3;  assign i3.as_n = as_n;  assign i3.rw = rw;
    assign i3.addr = addr; assign i3.wr_data = wdat;

    bus_slave_mem #(.ADDR_W(12), .DATA_W(32), .WAIT_CYC(0)) d0 (.clk(clk), .resetn(resetn), .bus(i0.slave));
    bus_slave_mem #(.ADDR_W(12), .DATA_W(32), .WAIT_CYC(1)) d1 (.clk(clk), .resetn(resetn), .bus(i1.slave));
    bus_slave_mem #(.ADDR_W(12), .DATA_W(32), .WAIT_CYC(3)) d3 (.clk(clk), .resetn(resetn), .bus(i3.slave));

    function automatic logic rdy(input int s);
        case (s)
            0:       return i0.rdy_n;
            1:       return i1.rdy_n;
            default: return i3.rdy_n;
        endcase
    endfunction

    function automatic logic [31:0] rdd(input int s);
        case (s)
            0:       return i0.rd_data;
            1:       return i1.rd_data;
            default: return i3.rd_data;
        endcase
    endfunction

    task automatic set_cs(input int s, input logic v);
        case (s)
            0:       cs0 = v;
            1:       cs1 = v;
            default: cs3 = v;
        endcase
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Issues one access, scrambles addr/data after capture, stops on the rdy_n-low cycle.
    task automatic do_access(input int s, input logic r, input logic [11:0] a, input logic [31:0] d,
                             output int lat, output logic [31:0] q);
        set_cs(s, 1'b0);
        as_n = 1'b0; rw = r; addr = a; wdat = d;
        tick;
        as_n = 1'b1; set_cs(s, 1'b1); addr = ~a; wdat = ~d;
        lat = -1;
        q   = 32'hxxxx_xxxx;
        for (int n = 1; n <= 20; n++) begin
            tick;
            if (rdy(s) == 1'b0) begin
                lat = n;
                q   = rdd(s);
                break;
            end
        end
    endtask

    task automatic xfer(input int s, input logic r, input logic [11:0] a, input logic [31:0] d,
                        input int exp_lat, input logic [31:0] exp_q, input string tag);
        int          lat;
        logic [31:0] q;
        do_access(s, r, a, d, lat, q);
        chk({tag, "_lat"}, 32'(lat), 32'(exp_lat));
        chk({tag, "_data"}, q, exp_q);
        tick;
        chk({tag, "_rdy_after"}, 32'(rdy(s)), 32'd1);
        chk({tag, "_data_after"}, rdd(s), 32'd0);
    endtask

    initial begin
        int          lat;
        logic [31:0] q;
        logic        low_seen;

        resetn = 1'b0;
        cs0 = 1'b1; cs1 = 1'b1; cs3 = 1'b1;
        as_n = 1'b1; rw = 1'b1; addr = '0; wdat = '0;
        tick; tick;
        for (int s = 0; s < 3; s++) begin
            chk("reset_rdy", 32'(rdy(s)), 32'd1);
            chk("reset_data", rdd(s), 32'd0);
        end
        resetn = 1'b1;
        tick;

        // WAIT_CYC=3: seed a value, then abort an overwriting access mid-WAIT.
        xfer(3, 1'b0, 12'h010, 32'h1111_1111, 4, 32'h0, "w3_seed");
        cs3 = 1'b0; as_n = 1'b0; rw = 1'b0; addr = 12'h010; wdat = 32'hCAFE_F00D;
        tick;
        cs3 = 1'b1; as_n = 1'b1;
        tick;
        resetn = 1'b0;
        #1;
        chk("abort_rdy", 32'(rdy(3)), 32'd1);
        chk("abort_data", rdd(3), 32'd0);
        tick;
        resetn = 1'b1;
        tick;
        xfer(3, 1'b1, 12'h010, 32'h0, 4, 32'h1111_1111, "r3_after_abort");

        // Reset landing on the rdy_n pulse drops the outputs at once.
        do_access(3, 1'b1, 12'h010, 32'h0, lat, q);
        chk("pulse_data", q, 32'h1111_1111);
        resetn = 1'b0;
        #1;
        chk("pulse_reset_rdy", 32'(rdy(3)), 32'd1);
        chk("pulse_reset_data", rdd(3), 32'd0);
        tick;
        resetn = 1'b1;
        tick;

        // WAIT_CYC=1 write then read.
        xfer(1, 1'b0, 12'h123, 32'hDEAD_BEEF, 2, 32'h0, "w1_123");
        xfer(1, 1'b1, 12'h123, 32'h0, 2, 32'hDEAD_BEEF, "r1_123");

        // WAIT_CYC=0 write then read.
        xfer(0, 1'b0, 12'h000, 32'h0000_0001, 1, 32'h0, "w0_000");
        xfer(0, 1'b1, 12'h000, 32'h0, 1, 32'h0000_0001, "r0_000");

        // Back-to-back reads with as_n held low across the first pulse.
        xfer(1, 1'b0, 12'h001, 32'hA1A1_A1A1, 2, 32'h0, "w1_001");
        xfer(1, 1'b0, 12'h002, 32'hB2B2_B2B2, 2, 32'h0, "w1_002");
        cs1 = 1'b0; as_n = 1'b0; rw = 1'b1; addr = 12'h001;
        tick;
        addr = 12'h002;
        tick; tick;
        chk("b2b_first_rdy", 32'(rdy(1)), 32'd0);
        chk("b2b_first_data", rdd(1), 32'hA1A1_A1A1);
        tick;
        chk("b2b_gap_rdy", 32'(rdy(1)), 32'd1);
        chk("b2b_gap_data", rdd(1), 32'd0);
        addr = 12'h7FF;
        tick; tick;
        chk("b2b_second_rdy", 32'(rdy(1)), 32'd0);
        chk("b2b_second_data", rdd(1), 32'hB2B2_B2B2);
        as_n = 1'b1; cs1 = 1'b1;
        tick;
        chk("b2b_end_rdy", 32'(rdy(1)), 32'd1);

        // Strobe without chip select is not an access.
        as_n = 1'b0; rw = 1'b1;
        low_seen = 1'b0;
        for (int n = 0; n < 10; n++) begin
            tick;
            if (rdy(0) == 1'b0 || rdy(1) == 1'b0 || rdy(3) == 1'b0) low_seen = 1'b1;
        end
        as_n = 1'b1;
        chk("no_cs_rdy_low", 32'(low_seen), 32'd0);

        // Address churn during WAIT; the complement address holds a decoy value.
        xfer(3, 1'b0, 12'hFFA, 32'h1234_5678, 4, 32'h0, "w3_decoy");
        xfer(3, 1'b0, 12'h005, 32'h55AA_55AA, 4, 32'h0, "w3_005");
        xfer(3, 1'b1, 12'h005, 32'h0, 4, 32'h55AA_55AA, "r3_005");

`ifdef BUS_SLAVE_MEM_PARITY_EN
        xfer(1, 1'b0, 12'h020, 32'h0000_000F, 2, 32'h0, "w1_par");
        d1.u_mem.mem[12'h020][0] = ~d1.u_mem.mem[12'h020][0];
        do_access(1, 1'b1, 12'h020, 32'h0, lat, q);
        chk("par_bad_err", 32'(i1.par_err), 32'd1);
        chk("par_bad_data", q, 32'h0000_000E);
        tick;
        chk("par_bad_err_after", 32'(i1.par_err), 32'd0);
        do_access(1, 1'b1, 12'h123, 32'h0, lat, q);
        chk("par_clean_err", 32'(i1.par_err), 32'd0);
        chk("par_clean_data", q, 32'hDEAD_BEEF);
        tick;
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
